// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-client line-transfer memory arbiter.
// Client IDs double as bit positions in the one-hot grant vector.
package mem_arbiter_pkg;

    localparam int REG_SIZE = 32;
    localparam int WIDTH    = 128;
    localparam int NUM_CLI  = 3;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        CLI_IC = 2'd0,
        CLI_DR = 2'd1,
        CLI_DW = 2'd2
    } cli_t;

    function automatic cli_t onehot_to_cli(input logic [NUM_CLI-1:0] onehot);
        cli_t cli;
        cli = CLI_IC;
        if (onehot[CLI_DR]) cli = CLI_DR;
        if (onehot[CLI_DW]) cli = CLI_DW;
        return cli;
    endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational client pick: eviction first so a dirty line leaves before its
// replacement arrives, then round-robin between the two refill clients.
module arb_select
    import mem_arbiter_pkg::*;
(
    input  logic               i_ic_req,
    input  logic               i_dr_req,
    input  logic               i_dw_req,
    input  cli_t               i_last_grant,
    output logic [NUM_CLI-1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        if (i_dw_req) begin
            o_grant[CLI_DW] = 1'b1;
        end else if (i_ic_req && i_dr_req) begin
            if (i_last_grant == CLI_IC) o_grant[CLI_DR] = 1'b1;
            else                        o_grant[CLI_IC] = 1'b1;
        end else if (i_ic_req) begin
            o_grant[CLI_IC] = 1'b1;
        end else if (i_dr_req) begin
            o_grant[CLI_DR] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises Icache refill, Dcache refill and Dcache eviction onto one
// asynchronous memory port, one line transfer at a time.
//
//   state       | meaning
//   ARB_IDLE    | waiting for a request; grant taken at the clock edge
//   ARB_BUSY    | mem_enable high, mem_* frozen, waiting for mem_ack
//   ARB_RELEASE | ack pulsed, waiting for memory to drop mem_ack
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_SIZE,
    parameter int LINE_W = WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic [LINE_W-1:0] ic_read_data,
    output logic              ic_read_ack,
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic [LINE_W-1:0] dc_read_data,
    output logic              dc_read_ack,
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    output logic              mem_enable,
    output logic              mem_rw,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_data_in,
    output logic [LINE_W-1:0] mem_data_out
);

    arb_state_t         r_state, w_state_nxt;
    cli_t               r_cli, r_last_grant;
    logic [NUM_CLI-1:0] w_grant;
    logic               w_start, w_done, w_req_held;

    logic               r_mem_enable, r_mem_rw;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [LINE_W-1:0]  r_mem_data_out, r_ic_data, r_dc_data;
    logic               r_ic_ack, r_dr_ack, r_dw_ack;

    arb_select u_sel (
        .i_ic_req     (ic_read_req),
        .i_dr_req     (dc_read_req),
        .i_dw_req     (dc_write_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ARB_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                w_start = |w_grant;
                if (w_start) w_state_nxt = ARB_BUSY;
            end
            ARB_BUSY: begin
                w_done = mem_ack;
                if (w_done) w_state_nxt = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                if (!mem_ack) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_enable   <= 1'b0;
            r_mem_rw       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data_out <= '0;
            r_ic_data      <= '0;
            r_dc_data      <= '0;
            r_ic_ack       <= 1'b0;
            r_dr_ack       <= 1'b0;
            r_dw_ack       <= 1'b0;
            r_cli          <= CLI_IC;
            r_last_grant   <= CLI_DR;
        end else begin
            r_ic_ack <= 1'b0;
            r_dr_ack <= 1'b0;
            r_dw_ack <= 1'b0;
            if (w_start) begin
                r_mem_enable <= 1'b1;
                r_cli        <= onehot_to_cli(w_grant);
                if (w_grant[CLI_DW]) begin
                    r_mem_rw       <= 1'b1;
                    r_mem_addr     <= dc_write_addr;
                    r_mem_data_out <= dc_write_data;
                end else if (w_grant[CLI_DR]) begin
                    r_mem_rw   <= 1'b0;
                    r_mem_addr <= dc_read_addr;
                end else begin
                    r_mem_rw   <= 1'b0;
                    r_mem_addr <= ic_read_addr;
                end
            end
            if (w_done) begin
                r_mem_enable <= 1'b0;
                unique case (r_cli)
                    CLI_IC: begin
                        r_ic_data    <= mem_data_in;
                        r_ic_ack     <= 1'b1;
                        r_last_grant <= CLI_IC;
                    end
                    CLI_DR: begin
                        r_dc_data    <= mem_data_in;
                        r_dr_ack     <= 1'b1;
                        r_last_grant <= CLI_DR;
                    end
                    default: r_dw_ack <= 1'b1;
                endcase
            end
        end
    end

    assign w_req_held = (r_cli == CLI_IC) ? ic_read_req :
                        (r_cli == CLI_DR) ? dc_read_req : dc_write_req;

    // A client must keep its request up for the whole transfer.
    a_req_held: assert property (@(posedge clk) disable iff (reset)
                                 (r_state == ARB_BUSY) |-> w_req_held);

    assign mem_enable   = r_mem_enable;
    assign mem_rw       = r_mem_rw;
    assign mem_addr     = r_mem_addr;
    assign mem_data_out = r_mem_data_out;
    assign ic_read_data = r_ic_data;
    assign dc_read_data = r_dc_data;
    assign ic_read_ack  = r_ic_ack;
    assign dc_read_ack  = r_dr_ack;
    assign dc_write_ack = r_dw_ack;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared asynchronous main-memory port between three cache-side clients: Icache line refill (ic_read), Dcache line refill (dc_read) and Dcache dirty-line eviction (dc_write).
- Sits between the Icache/Dcache miss interfaces and memory_async. Serialises one line transfer at a time and returns read data and an ack pulse to the granted client.

Parameters:
- ADDR_W, 32, address width (equals REG_SIZE).
- LINE_W, 128, cache line / memory data width (equals WIDTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ic_read_req  in  1  Icache refill request; held until ic_read_ack.
- ic_read_addr  in  ADDR_W  Icache refill line address.
- ic_read_data  out  LINE_W  refill line returned to the Icache.
- ic_read_ack  out  1  one-cycle completion pulse.
- dc_read_req  in  1  Dcache refill request; held until dc_read_ack.
- dc_read_addr  in  ADDR_W  Dcache refill line address.
- dc_read_data  out  LINE_W  refill line returned to the Dcache.
- dc_read_ack  out  1  one-cycle completion pulse.
- dc_write_req  in  1  Dcache eviction request; held until dc_write_ack.
- dc_write_addr  in  ADDR_W  eviction line address.
- dc_write_data  in  LINE_W  eviction line data.
- dc_write_ack  out  1  one-cycle completion pulse.
- mem_enable  out  1  memory transaction enable.
- mem_rw  out  1  1 = write, 0 = read.
- mem_ack  in  1  memory done; stays high while mem_enable is high.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  in  LINE_W  read data from memory.
- mem_data_out  out  LINE_W  write data to memory.

Behaviour:
- Reset (sync, active-high): state=IDLE. mem_enable=0, mem_rw=0, mem_addr=0, mem_data_out=0. All acks=0. ic_read_data=0, dc_read_data=0. last_grant=DC, so the first contended read goes to the IC. Reset mid-transaction aborts immediately with no ack issued; clients re-request.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE: if any req is high, grant one client at the clock edge:
  - dc_write_req has absolute priority, so an eviction always precedes the refill that replaces it.
  - Otherwise, ic_read vs dc_read is round-robin: the client not equal to last_grant wins when both are requesting; a sole requester always wins.
  - On grant, register the granted address, mem_rw, and write data (dc_write only) into mem_addr/mem_rw/mem_data_out. Set mem_enable=1 and go to BUSY.
  - Grant decision to mem_enable high takes 1 cycle.
- BUSY: hold all mem_* outputs stable. When mem_ack is sampled 1:
  - drop mem_enable;
  - for a read, capture mem_data_in into the granted client's data register;
  - pulse the granted client's ack for exactly 1 cycle;
  - update last_grant (reads only);
  - go to RELEASE.
- RELEASE: remain here until mem_ack is sampled 0, then go to IDLE. This takes at least 1 cycle.
  - Requests are ignored in RELEASE, so a client dropping req the cycle after its ack is never re-granted.
- Client data outputs hold their last captured value until the next read completion for that client.
- Client request withdrawn during BUSY is illegal (flagged by a simulation assertion). The arbiter still completes the transaction and pulses the ack.
- At most one ack is high in any cycle. mem_addr, mem_rw and mem_data_out do not change while mem_enable=1.
- Minimum turnaround: grant(1) + memory latency + release(1). Back-to-back requests are granted in the first IDLE cycle after RELEASE.
- mem_ack high while in IDLE (stale ack) is ignored.

Decomposition:
- Shared package/define file:
  - FSM state encodings (ARB_IDLE, ARB_BUSY, ARB_RELEASE).
  - Client IDs (CLI_IC, CLI_DR, CLI_DW).
  - Reuse the existing REG_SIZE/WIDTH defines as parameter defaults.
- One natural sub-module, arb_select: combinational priority + round-robin pick taking the three reqs and last_grant, returning a one-hot grant. The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Single IC read: ic_read_req=1, addr=0x0000_0040; memory acks after 3 cycles with data 0xDEADBEEF_... -> mem_enable=1 / mem_rw=0 / mem_addr=0x40 one cycle after req. ic_read_ack pulses once with ic_read_data equal to that data. dc acks stay 0.
- Write priority: dc_write_req(addr 0x100, data 0x1111…) and dc_read_req(addr 0x200) raised in the same cycle -> write to 0x100 with mem_rw=1 is issued first. The read of 0x200 follows after RELEASE; dc_write_ack precedes dc_read_ack.
- Round-robin: ic and dc read requests held continuously for 4 transactions -> grants alternate IC, DC, IC, DC starting with IC after reset.
- Slow ack release: memory holds mem_ack high 3 extra cycles after mem_enable drops -> FSM stays in RELEASE and no new grant occurs until mem_ack=0. The client ack is still exactly 1 cycle wide.
- Reset mid-op: assert reset during BUSY -> next cycle mem_enable=0, all acks=0, state IDLE. A subsequent request completes normally.
- Stability check: during every BUSY, mem_addr, mem_rw and mem_data_out remain unchanged while client addr/data inputs toggle randomly.
